// File: rtl/top_block_code_pkg.sv
// Shared definitions for the (20,A) block-code soft decoder: basis table, sizing constants,
// controller states and small helpers.
package top_block_code_pkg;

  localparam int unsigned MAX_A        = 13;
  localparam int unsigned NUM_CODED    = 20;
  localparam int unsigned METRIC_GUARD = 6;   // metric width = DATA_WIDTH + METRIC_GUARD
  localparam int unsigned A_W          = 4;
  localparam int unsigned CAND_W       = MAX_A + 1;

  typedef enum logic [1:0] {
    StCollect,
    StSearch,
    StOutput
  } state_e;

  // Basis sequences M_n,0..M_n,12 laid out one row per coded bit n, leftmost entry is M_n,0.
  localparam logic [0:MAX_A-1] BASIS_ROWS [NUM_CODED] = '{
    13'b1100000000110,
    13'b1110000001110,
    13'b1001001011111,
    13'b1011000010111,
    13'b1111000100111,
    13'b1100101110111,
    13'b1010101011111,
    13'b1001100110111,
    13'b1101100101111,
    13'b1011101001111,
    13'b1010011101111,
    13'b1110011010111,
    13'b1001010111111,
    13'b1101010101111,
    13'b1000110100101,
    13'b1100111101101,
    13'b1110111001011,
    13'b1001110010011,
    13'b1101111100000,
    13'b1000011000000
  };

  // Column i of the table: the 20 coded-bit contributions of info bit a_i.
  function automatic logic [NUM_CODED-1:0] basis_col(input int unsigned i);
    logic [NUM_CODED-1:0] col;
    col = '0;
    for (int unsigned n = 0; n < NUM_CODED; n++) begin
      col[n] = BASIS_ROWS[n][i];
    end
    return col;
  endfunction

  function automatic logic [A_W-1:0] clamp_len(input logic [7:0] len);
    if (len == 8'd0) begin
      return A_W'(1);
    end else if (len > 8'(MAX_A)) begin
      return A_W'(MAX_A);
    end else begin
      return len[A_W-1:0];
    end
  endfunction

endpackage

// File: rtl/rm20_encoder.sv
// Combinational (20,A) encoder: XOR of the basis columns selected by the low A message bits.
module rm20_encoder
  import top_block_code_pkg::*;
(
  input  logic [MAX_A-1:0]     msg_i,
  input  logic [A_W-1:0]       a_len_i,
  output logic [NUM_CODED-1:0] code_o
);

  always_comb begin
    code_o = '0;
    for (int unsigned i = 0; i < MAX_A; i++) begin
      if ((i < 32'(a_len_i)) && msg_i[i]) begin
        code_o = code_o ^ basis_col(i);
      end
    end
  end

endmodule

// File: rtl/top_block_code.sv
// Exhaustive maximum-likelihood soft decoder for the (20,A) block code: collect 20 LLRs,
// correlate against every candidate message, then stream out the best one bit by bit.
module top_block_code
  import top_block_code_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned NUM_SYMBOLS = 20
) (
  input  logic                  clk,
  input  logic                  s_axis_aresetn,
  input  logic [7:0]            code_length,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast
);

  localparam int unsigned MW = DATA_WIDTH + METRIC_GUARD;
  localparam logic signed [MW-1:0] METRIC_MIN = {1'b1, {(MW-1){1'b0}}};

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] sym_q [NUM_SYMBOLS];
  logic signed [DATA_WIDTH-1:0] sym_d [NUM_SYMBOLS];
  logic [4:0]                   sym_cnt_q, sym_cnt_d;
  logic [A_W-1:0]               a_len_q, a_len_d;
  logic [CAND_W-1:0]            cnt_q, cnt_d;
  logic                         pipe_vld_q, pipe_vld_d;
  logic signed [MW-1:0]         pipe_metric_q, pipe_metric_d;
  logic [MAX_A-1:0]             pipe_cand_q, pipe_cand_d;
  logic signed [MW-1:0]         best_metric_q, best_metric_d;
  logic [MAX_A-1:0]             best_cand_q, best_cand_d;
  logic [A_W-1:0]               out_idx_q, out_idx_d;
  logic                         tdata_q, tdata_d;
  logic                         tvalid_q, tvalid_d;
  logic                         tlast_q, tlast_d;

  logic [NUM_CODED-1:0]         cand_code;
  logic signed [MW-1:0]         cand_metric;
  logic [CAND_W-1:0]            num_cand;

  assign num_cand = CAND_W'(1) << a_len_q;

  rm20_encoder u_encoder (
    .msg_i   (cnt_q[MAX_A-1:0]),
    .a_len_i (a_len_q),
    .code_o  (cand_code)
  );

  // Correlation metric: add the LLR where the candidate codes a 0, subtract it where it codes a 1.
  always_comb begin
    logic signed [MW-1:0] sx;
    sx          = '0;
    cand_metric = '0;
    for (int unsigned n = 0; n < NUM_CODED; n++) begin
      sx = MW'(sym_q[n]);
      cand_metric = cand_code[n] ? (cand_metric - sx) : (cand_metric + sx);
    end
  end

  always_comb begin
    state_d       = state_q;
    sym_d         = sym_q;
    sym_cnt_d     = sym_cnt_q;
    a_len_d       = a_len_q;
    cnt_d         = cnt_q;
    pipe_vld_d    = 1'b0;
    pipe_metric_d = pipe_metric_q;
    pipe_cand_d   = pipe_cand_q;
    best_metric_d = best_metric_q;
    best_cand_d   = best_cand_q;
    out_idx_d     = out_idx_q;
    tdata_d       = 1'b0;
    tvalid_d      = 1'b0;
    tlast_d       = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (s_axis_tvalid) begin
          sym_d[sym_cnt_q] = s_axis_tdata;
          if (sym_cnt_q == 5'd0) begin
            a_len_d = clamp_len(code_length);
          end
          if (sym_cnt_q == 5'(NUM_SYMBOLS - 1)) begin
            sym_cnt_d     = '0;
            cnt_d         = '0;
            best_metric_d = METRIC_MIN;
            best_cand_d   = '0;
            state_d       = StSearch;
          end else begin
            sym_cnt_d = sym_cnt_q + 5'd1;
          end
        end
      end

      StSearch: begin
        // Metric is registered before comparison, so the search runs one cycle past the last candidate.
        if (cnt_q != num_cand) begin
          pipe_vld_d    = 1'b1;
          pipe_metric_d = cand_metric;
          pipe_cand_d   = cnt_q[MAX_A-1:0];
          cnt_d         = cnt_q + CAND_W'(1);
        end
        if (pipe_vld_q && (pipe_metric_q > best_metric_q)) begin
          best_metric_d = pipe_metric_q;
          best_cand_d   = pipe_cand_q;
        end
        if (cnt_q == num_cand) begin
          out_idx_d = '0;
          state_d   = StOutput;
        end
      end

      StOutput: begin
        tvalid_d = 1'b1;
        tdata_d  = best_cand_q[out_idx_q];
        if (out_idx_q == a_len_q - A_W'(1)) begin
          tlast_d   = 1'b1;
          out_idx_d = '0;
          state_d   = StCollect;
        end else begin
          out_idx_d = out_idx_q + A_W'(1);
        end
      end

      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q       <= StCollect;
      for (int unsigned n = 0; n < NUM_SYMBOLS; n++) begin
        sym_q[n] <= '0;
      end
      sym_cnt_q     <= '0;
      a_len_q       <= A_W'(1);
      cnt_q         <= '0;
      pipe_vld_q    <= 1'b0;
      pipe_metric_q <= '0;
      pipe_cand_q   <= '0;
      best_metric_q <= METRIC_MIN;
      best_cand_q   <= '0;
      out_idx_q     <= '0;
      tdata_q       <= 1'b0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sym_q         <= sym_d;
      sym_cnt_q     <= sym_cnt_d;
      a_len_q       <= a_len_d;
      cnt_q         <= cnt_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_metric_q <= pipe_metric_d;
      pipe_cand_q   <= pipe_cand_d;
      best_metric_q <= best_metric_d;
      best_cand_q   <= best_cand_d;
      out_idx_q     <= out_idx_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_top_block_code.sv
// Directed and random blocks checked against an integer brute-force ML decoder model.
module tb_top_block_code;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          s_axis_aresetn;
  logic [7:0]    code_length;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;

  int errors = 0;
  int checks = 0;

  logic signed [DW-1:0] blk [20];

  // Independent copy of the code definition, one row per coded bit, leftmost entry is info bit 0.
  localparam logic [0:12] TAB [20] = '{
    13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
    13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
    13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
    13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
    13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000
  };

  top_block_code #(
    .DATA_WIDTH  (DW),
    .NUM_SYMBOLS (20)
  ) dut (
    .clk            (clk),
    .s_axis_aresetn (s_axis_aresetn),
    .code_length    (code_length),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int cl);
    if (cl == 0) return 1;
    if (cl > 13) return 13;
    return cl;
  endfunction

  function automatic bit code_bit(input int a, input int msg, input int n);
    bit b = 1'b0;
    for (int i = 0; i < a; i++) begin
      if (((msg >> i) & 1) == 1 && TAB[n][i]) b = ~b;
    end
    return b;
  endfunction

  // Brute-force ML: largest correlation wins, earliest candidate wins ties.
  function automatic int ml_decode(input int a);
    int best = -1000000;
    int arg  = 0;
    for (int c = 0; c < (1 << a); c++) begin
      int m = 0;
      for (int n = 0; n < 20; n++) begin
        m += code_bit(a, c, n) ? -int'(blk[n]) : int'(blk[n]);
      end
      if (m > best) begin
        best = m;
        arg  = c;
      end
    end
    return arg;
  endfunction

  task automatic encode_block(input int a, input int msg, input int pos, input int neg);
    for (int n = 0; n < 20; n++) begin
      blk[n] = code_bit(a, msg, n) ? DW'(neg) : DW'(pos);
    end
  endtask

  task automatic random_block();
    for (int n = 0; n < 20; n++) blk[n] = DW'($urandom);
  endtask

  task automatic send_block(input int cl);
    for (int k = 0; k < 20; k++) begin
      s_axis_tdata  = blk[k];
      s_axis_tvalid = 1'b1;
      code_length   = (k == 0) ? 8'(cl) : 8'($urandom);
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic receive(input int cl, input bit extras, input string tag);
    int a   = eff_len(cl);
    int exp = ml_decode(a);
    int lat = 0;
    while (!m_axis_tvalid && lat < 9000) begin
      if (extras && lat < (1 << a)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = DW'($urandom);
      end else begin
        s_axis_tvalid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    s_axis_tvalid = 1'b0;
    check($sformatf("%s.latency", tag), lat, (1 << a) + 2);
    if (!m_axis_tvalid) return;
    for (int j = 0; j < a; j++) begin
      check($sformatf("%s.tvalid[%0d]", tag, j), m_axis_tvalid, 1);
      check($sformatf("%s.tdata[%0d]", tag, j), m_axis_tdata, (exp >> j) & 1);
      check($sformatf("%s.tlast[%0d]", tag, j), m_axis_tlast, (j == a - 1) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    check($sformatf("%s.gap", tag), m_axis_tvalid, 0);
  endtask

  initial begin
    int msg;
    int beats;
    s_axis_aresetn = 1'b0;
    code_length    = '0;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.tvalid", m_axis_tvalid, 0);
    check("reset.tdata", m_axis_tdata, 0);
    check("reset.tlast", m_axis_tlast, 0);
    s_axis_aresetn = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 20; n++) blk[n] = DW'(7);
    send_block(5);
    receive(5, 1'b0, "all_pos");

    encode_block(5, 13, 7, -8);  // a = 1,0,1,1,0
    send_block(5);
    receive(5, 1'b0, "clean_a5");
    check("clean_a5.model", ml_decode(5), 13);

    encode_block(5, 13, 7, -8);
    foreach (blk[n]) begin
      if (n == 2 || n == 9 || n == 15) blk[n] = (blk[n] == DW'(7)) ? DW'(-7) : DW'(7);
    end
    send_block(5);
    receive(5, 1'b0, "flipped_a5");

    for (int n = 0; n < 20; n++) blk[n] = '0;
    send_block(8);
    receive(8, 1'b0, "all_zero");

    msg = int'($urandom_range(0, 8191));
    encode_block(13, msg, 5, -5);
    send_block(13);
    receive(13, 1'b0, "clean_a13");
    check("clean_a13.model", ml_decode(13), msg);

    random_block();
    send_block(0);
    receive(0, 1'b0, "clamp_low");

    random_block();
    send_block(200);
    receive(200, 1'b0, "clamp_high");

    // Reset mid-search must abort the block without emitting anything.
    encode_block(5, int'($urandom_range(0, 31)), 7, -8);
    send_block(5);
    repeat (10) @(posedge clk);
    #1;
    s_axis_aresetn = 1'b0;
    #2;
    check("midreset.tvalid", m_axis_tvalid, 0);
    repeat (2) @(posedge clk);
    #1;
    check("midreset.tlast", m_axis_tlast, 0);
    s_axis_aresetn = 1'b1;
    beats = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (m_axis_tvalid) beats++;
    end
    check("midreset.no_beats", beats, 0);
    encode_block(5, int'($urandom_range(0, 31)), 6, -6);
    send_block(5);
    receive(5, 1'b0, "after_reset");

    encode_block(13, int'($urandom_range(0, 8191)), 7, -8);
    send_block(13);
    receive(13, 1'b1, "b2b_a13");
    encode_block(5, int'($urandom_range(0, 31)), 7, -8);
    send_block(5);
    receive(5, 1'b1, "b2b_a5");

    for (int r = 0; r < 6; r++) begin
      int cl = int'($urandom_range(1, 9));
      random_block();
      send_block(cl);
      receive(cl, r[0], $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
